// File: rtl/demod_slicer_pkg.sv
// Shared types and helpers for the 16QAM symbol-decision stage.
package demod_pkg;

  typedef logic [1:0] sym2_t;

  // Natural offset binary levels; Gray/differential decoding happens downstream.
  localparam sym2_t LVL_M3 = 2'b00;
  localparam sym2_t LVL_M1 = 2'b01;
  localparam sym2_t LVL_P1 = 2'b10;
  localparam sym2_t LVL_P3 = 2'b11;

  function automatic int unsigned acc_width(input int unsigned sample_w,
                                            input int unsigned sps);
    return sample_w + $clog2(sps);
  endfunction

endpackage

// File: rtl/demod_slicer_if.sv
// Sample-in / decision-out bundle between the front end and the slicer.
interface demod_slicer_if
  import demod_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 12
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] i_sample;
  logic signed [SAMPLE_W-1:0] q_sample;
  logic                       sym_align;
  sym2_t                      sym_i;
  sym2_t                      sym_q;
  logic                       sym_valid;

  modport master (
    output sample_valid, i_sample, q_sample, sym_align,
    input  sym_i, sym_q, sym_valid
  );

  modport slave (
    input  sample_valid, i_sample, q_sample, sym_align,
    output sym_i, sym_q, sym_valid
  );
endinterface

// File: rtl/demod_slicer_axis.sv
// One axis: integrate-and-dump, saturating magnitude and four-level slice.
module slicer_axis
  import demod_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned ACC_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic                       i_align,
  input  logic                       i_last,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic        [ACC_W-1:0]    i_thr,
  output logic        [ACC_W-1:0]    o_mag,
  output sym2_t                      o_lvl
);
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_acc_d;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic        [ACC_W-1:0] w_raw;
  logic                    w_neg;
  logic                    w_ge;

  assign w_ext = {{(ACC_W-SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample};
  assign w_sum = r_acc + w_ext;
  assign w_raw = r_acc_d;
  assign w_neg = w_raw[ACC_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_acc_d <= '0;
    end else if (i_align) begin
      r_acc <= i_valid ? w_ext : '0;
    end else if (i_valid) begin
      if (i_last) begin
        r_acc_d <= w_sum;
        r_acc   <= '0;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  always_comb begin
    o_mag = w_raw;
    if (w_neg) o_mag = (w_raw == ACC_MIN) ? ACC_MAX : (~w_raw + ACC_W'(1));
  end

  assign w_ge = (o_mag >= i_thr);

  always_comb begin
    o_lvl = LVL_P1;
    case ({w_neg, w_ge})
      2'b11:   o_lvl = LVL_M3;
      2'b10:   o_lvl = LVL_M1;
      2'b00:   o_lvl = LVL_P1;
      default: o_lvl = LVL_P3;
    endcase
  end

endmodule

// File: rtl/demod_slicer.sv
// 16QAM symbol decision: I/Q integrate-and-dump, adaptive threshold, lock flag.
module demod_slicer
  import demod_pkg::*;
#(
  parameter  int unsigned SAMPLE_W  = 12,
  parameter  int unsigned SPS       = 16,
  parameter  int unsigned AVG_SHIFT = 4,
  parameter  int unsigned THR_INIT  = 2048,
  parameter  int unsigned LOCK_SYMS = 64,
  localparam int unsigned ACC_W     = acc_width(SAMPLE_W, SPS)
) (
  input  logic              clk,
  input  logic              rst,
  demod_slicer_if.slave     bus,
  output logic [ACC_W-1:0]  threshold,
  output logic              locked
);
  localparam int unsigned TW    = ACC_W + AVG_SHIFT;
  localparam int unsigned CNT_W = $clog2(SPS);
  localparam int unsigned LCW   = $clog2(LOCK_SYMS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPS - 1);
  localparam logic [LCW-1:0]   LOCK_MAX  = LCW'(LOCK_SYMS);
  localparam logic [TW-1:0]    THR_RST   = TW'(THR_INIT) << AVG_SHIFT;
  localparam logic [TW:0]      THR_FLOOR = (TW+1)'(1) << AVG_SHIFT;

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic [TW-1:0]    r_thr;
  logic [LCW-1:0]   r_lock_cnt;
  logic             r_locked;

  logic             w_last;
  logic [ACC_W-1:0] w_mag_i;
  logic [ACC_W-1:0] w_mag_q;
  sym2_t            w_lvl_i;
  sym2_t            w_lvl_q;
  logic [ACC_W:0]   w_magsum;
  logic [ACC_W-1:0] w_half;
  logic [TW:0]      w_upd;

  assign w_last = (r_cnt == CNT_LAST);

  slicer_axis #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_axis_i (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (bus.sample_valid),
    .i_align  (bus.sym_align),
    .i_last   (w_last),
    .i_sample (bus.i_sample),
    .i_thr    (threshold),
    .o_mag    (w_mag_i),
    .o_lvl    (w_lvl_i)
  );

  slicer_axis #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_axis_q (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (bus.sample_valid),
    .i_align  (bus.sym_align),
    .i_last   (w_last),
    .i_sample (bus.q_sample),
    .i_thr    (threshold),
    .o_mag    (w_mag_q),
    .o_lvl    (w_lvl_q)
  );

  assign threshold = r_thr[TW-1:AVG_SHIFT];
  assign locked    = r_locked;

  // Averager step in TW+1 bits: the top bit flags overflow for ceiling saturation.
  assign w_magsum = {1'b0, w_mag_i} + {1'b0, w_mag_q};
  assign w_half   = ACC_W'(w_magsum >> 1);
  assign w_upd    = {1'b0, r_thr} + {{(AVG_SHIFT+1){1'b0}}, w_half}
                  - {{(AVG_SHIFT+1){1'b0}}, threshold};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= bus.sample_valid && w_last && !bus.sym_align;
      if (bus.sym_align)
        r_cnt <= bus.sample_valid ? CNT_W'(1) : '0;
      else if (bus.sample_valid)
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sym_i     <= LVL_M3;
      bus.sym_q     <= LVL_M3;
      bus.sym_valid <= 1'b0;
      r_thr         <= THR_RST;
    end else begin
      bus.sym_valid <= r_pend;
      if (r_pend) begin
        bus.sym_i <= w_lvl_i;
        bus.sym_q <= w_lvl_q;
        if (w_upd[TW])              r_thr <= '1;
        else if (w_upd < THR_FLOOR) r_thr <= THR_FLOOR[TW-1:0];
        else                        r_thr <= w_upd[TW-1:0];
      end
    end
  end

  // Align restarts the lock count and drops locked on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (bus.sym_align) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_locked <= (r_lock_cnt >= LOCK_MAX);
      if (r_pend && (r_lock_cnt != LOCK_MAX)) r_lock_cnt <= r_lock_cnt + LCW'(1);
    end
  end

endmodule

// File: tb/tb_demod_slicer.sv
// Directed and randomized checks of demod_slicer against a list-based symbol model.
module tb_demod_slicer;
  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned SPS       = 4;
  localparam int unsigned AVG_SHIFT = 4;
  localparam int unsigned THR_INIT  = 800;
  localparam int unsigned LOCK_SYMS = 64;
  localparam int unsigned ACC_W     = 14;
  localparam int          MAG_MAX   = 8191;
  localparam int          THR_MAX   = 262143;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ACC_W-1:0] threshold;
  logic             locked;

  always #5 clk = ~clk;

  demod_slicer_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  demod_slicer #(
    .SAMPLE_W  (SAMPLE_W),
    .SPS       (SPS),
    .AVG_SHIFT (AVG_SHIFT),
    .THR_INIT  (THR_INIT),
    .LOCK_SYMS (LOCK_SYMS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .threshold (threshold),
    .locked    (locked)
  );

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  // Model: samples of the symbol in progress, a finished symbol awaiting decision,
  // and the expected registered outputs.
  int qi[$];
  int qq[$];
  bit m_pend;
  int m_si, m_sq;
  int m_thr;
  int m_lock;
  bit m_locked;
  int e_symi, e_symq;
  bit e_valid;

  function automatic int mag_of(input int s);
    int m;
    m = (s < 0) ? -s : s;
    return (m > MAG_MAX) ? MAG_MAX : m;
  endfunction

  function automatic int level(input int s, input int thr);
    if (s < 0) return (mag_of(s) >= thr) ? 0 : 1;
    return (mag_of(s) >= thr) ? 3 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sym_valid", {31'd0, bus.sym_valid}, {31'd0, e_valid});
    chk("sym_i", {30'd0, bus.sym_i}, e_symi);
    chk("sym_q", {30'd0, bus.sym_q}, e_symq);
    chk("threshold", {18'd0, threshold}, m_thr / 16);
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
  endtask

  task automatic model_reset();
    qi.delete();
    qq.delete();
    m_pend = 0; m_si = 0; m_sq = 0;
    m_thr = THR_INIT * 16;
    m_lock = 0; m_locked = 0;
    e_symi = 0; e_symq = 0; e_valid = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sym_align = 1'b0;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit v, input int si, input int sq, input bit al);
    bit emit;
    int t;
    @(negedge clk);
    bus.sample_valid = v;
    bus.i_sample = si[11:0];
    bus.q_sample = sq[11:0];
    bus.sym_align = al;
    @(posedge clk);
    emit = m_pend;
    e_valid = emit;
    if (al) begin
      m_lock = 0;
      m_locked = 0;
    end else begin
      m_locked = (m_lock >= LOCK_SYMS);
      if (emit && m_lock < LOCK_SYMS) m_lock++;
    end
    if (emit) begin
      e_symi = level(m_si, m_thr / 16);
      e_symq = level(m_sq, m_thr / 16);
      t = m_thr + (mag_of(m_si) + mag_of(m_sq)) / 2 - m_thr / 16;
      if (t < 16) t = 16;
      if (t > THR_MAX) t = THR_MAX;
      m_thr = t;
    end
    m_pend = 0;
    if (al) begin
      qi.delete();
      qq.delete();
    end
    if (v) begin
      qi.push_back(si);
      qq.push_back(sq);
      if (!al && qi.size() == SPS) begin
        m_pend = 1;
        m_si = 0; m_sq = 0;
        foreach (qi[k]) begin
          m_si += qi[k];
          m_sq += qq[k];
        end
        qi.delete();
        qq.delete();
      end
    end
    #1;
    if (bus.sym_valid) strobes++;
    check_all();
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    int s0;
    bus.sample_valid = 1'b0;
    bus.i_sample = '0;
    bus.q_sample = '0;
    bus.sym_align = 1'b0;
    model_reset();

    do_reset(2);
    chk("rst_thr", {18'd0, threshold}, 32'd800);

    repeat (4) step(1, 300, -100, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("t1_sym_i", {30'd0, bus.sym_i}, 32'd3);
    chk("t1_sym_q", {30'd0, bus.sym_q}, 32'd1);
    chk("t1_thr", {18'd0, threshold}, 32'd800);

    repeat (4) step(1, -300, 300, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("t2_sym_i", {30'd0, bus.sym_i}, 32'd0);
    chk("t2_sym_q", {30'd0, bus.sym_q}, 32'd3);
    chk("t2_thr", {18'd0, threshold}, 32'd825);

    s0 = strobes;
    for (int k = 0; k < 16; k++) step(k % 2 == 0, rnd_sample(), rnd_sample(), 0);
    repeat (3) step(0, 0, 0, 0);
    chk("toggle_strobes", strobes - s0, 32'd2);

    repeat (2) step(1, 1000, 1000, 0);
    step(1, -200, 200, 1);
    s0 = strobes;
    repeat (3) step(1, -200, 200, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("align_strobes", strobes - s0, 32'd1);

    repeat (4) step(1, -2048, -2048, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("neg_sym_i", {30'd0, bus.sym_i}, 32'd0);
    chk("neg_sym_q", {30'd0, bus.sym_q}, 32'd0);

    do_reset(1);
    for (int k = 0; k < 64 * SPS; k++) step(1, rnd_sample(), rnd_sample(), 0);
    repeat (3) step(0, 0, 0, 0);
    chk("lock_high", {31'd0, locked}, 32'd1);
    step(1, 500, -500, 1);
    chk("align_unlock", {31'd0, locked}, 32'd0);
    step(1, 500, -500, 0);
    do_reset(1);
    chk("rst_sym_valid", {31'd0, bus.sym_valid}, 32'd0);
    s0 = strobes;
    repeat (3) step(1, 700, 700, 0);
    step(0, 0, 0, 0);
    chk("rst_no_strobe", strobes - s0, 32'd0);
    step(1, 700, 700, 0);
    repeat (2) step(0, 0, 0, 0);
    chk("rst_one_strobe", strobes - s0, 32'd1);

    for (int k = 0; k < 130 * SPS; k++) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    chk("thr_floor", {18'd0, threshold}, 32'd1);

    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample(), $urandom_range(0, 49) == 0);
    repeat (3) step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demod_slicer.md
Name: demod_slicer

Overview:
- Symbol-decision stage of the 16QAM receiver. Sits directly upstream of the demodulator parallel-to-serial stage.
- Integrates baseband I/Q samples over one symbol period (integrate-and-dump matched filter).
- Slices each axis into one of four levels using an adaptive amplitude threshold.
- Emits per-symbol 2-bit sym_i/sym_q with a one-cycle strobe. The downstream stage applies Gray/differential decoding.

Parameters:
- SAMPLE_W, 12, signed width of i_sample/q_sample.
- SPS, 16, samples per symbol (power of two, >=2).
- AVG_SHIFT, 4, time constant of the threshold averager (weight 2^-AVG_SHIFT).
- THR_INIT, 2048, threshold value loaded at reset (accumulator units).
- LOCK_SYMS, 64, symbols after reset/align before locked asserts.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  i_sample/q_sample valid this cycle.
- i_sample  in  SAMPLE_W  signed in-phase sample.
- q_sample  in  SAMPLE_W  signed quadrature sample.
- sym_align  in  1  pulse: the next accepted sample begins a new symbol.
- sym_i  out  2  in-phase decision.
- sym_q  out  2  quadrature decision.
- sym_valid  out  1  one-cycle strobe, decisions updated.
- threshold  out  ACC_W  current slicing threshold.
- locked  out  1  averager settled.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Widths:
  - ACC_W = SAMPLE_W + log2(SPS).
  - Accumulators are signed ACC_W bits and cannot overflow.
  - thr_reg is unsigned ACC_W+AVG_SHIFT bits; threshold = thr_reg >> AVG_SHIFT.
- Reset values:
  - Sample counter and both accumulators 0.
  - thr_reg = THR_INIT << AVG_SHIFT.
  - sym_i = sym_q = 2'b00, sym_valid = 0, locked = 0, lock counter 0.
- Integrate:
  - Each cycle with sample_valid, acc += sample and cnt increments.
  - When cnt == SPS-1 and sample_valid (cycle T), dump: acc_d = acc + sample, acc <= 0, cnt <= 0.
  - Dump registers are loaded at the end of T.
  - Cycles without sample_valid hold all state.
- Slice, evaluated at cycle T+1 and registered:
  - Per axis: mag = |acc_d|. Abs of the most negative value saturates to 2^(ACC_W-1)-1.
  - Level map (natural offset binary):
    - acc_d < 0 and mag >= thr gives 2'b00 (-3).
    - acc_d < 0 and mag < thr gives 2'b01 (-1).
    - acc_d >= 0 and mag < thr gives 2'b10 (+1).
    - acc_d >= 0 and mag >= thr gives 2'b11 (+3).
    - Zero counts as positive.
  - sym_i, sym_q and sym_valid=1 are visible at T+2. sym_valid is high for exactly one cycle.
  - Outputs hold between strobes.
- Threshold update, same edge as the slice:
  - thr_reg <= thr_reg + (mag_i + mag_q)/2 - (thr_reg >> AVG_SHIFT).
  - The slice uses the pre-update threshold.
  - Floor: thr_reg is never below 1 << AVG_SHIFT. Clamp if the update would go lower.
  - Ceiling: saturate at the all-ones value.
- Lock:
  - A saturating counter increments per emitted symbol.
  - locked = 1 once the count reaches LOCK_SYMS.
- sym_align:
  - Clears cnt and both accumulators, and clears the lock counter (locked drops the next cycle). thr_reg is kept.
  - If sample_valid is also high in the same cycle, that sample becomes sample 0 of the new symbol: acc = sample, cnt = 1.
  - A dump already in flight (T+1 pipeline) still completes and strobes.
- Mid-operation rst: aborts any in-flight dump. No sym_valid until a full SPS samples follow.
- Throughput: one sample per cycle sustained, with no gaps required between symbols.

Decomposition:
- Shared package demod_pkg holds:
  - Type sym2_t (2-bit).
  - Level constants LVL_M3=2'b00, LVL_M1=2'b01, LVL_P1=2'b10, LVL_P3=2'b11.
  - Function for the ACC_W calculation.
- One sub-module, slicer_axis: per-axis integrate-and-dump, saturating abs, and compare. It is instantiated twice.
- The threshold averager and lock counter live in the top.

Test Plan:
- Reset, SPS=4, AVG_SHIFT=4, THR_INIT=800; four valid samples i=+300, q=-100 -> acc_d 1200/-400; sym_i=11, sym_q=01, sym_valid one cycle at T+2; thr_reg 12800 -> 12800+800-800=12800, threshold stays 800.
- i=-300 x4, q=+300 x4 -> sym_i=00, sym_q=11; mag_i/q equal 1200, thr_reg -> 12800+1200-800=13200, threshold 825.
- Samples with sample_valid toggling every other cycle -> dump only after 4 accepted samples; sym_valid strobe count equals accepted/4.
- sym_align asserted with valid after 2 samples of a symbol -> partial symbol discarded, the next strobe covers exactly 4 samples starting at the align sample; locked drops.
- All samples -2048 (most negative), SPS=4, i and q -> acc_d -8192; mag saturates to 8191; sym=00 on both axes; thr_reg never wraps.
- 64 consecutive symbols after reset with LOCK_SYMS=64 -> locked rises the cycle after the 64th strobe; rst asserted mid-symbol -> no strobe until 4 fresh samples, all outputs at reset values.
